// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - Moore FSM sequencing the multi-cycle datapath
module multicycle_control_unit #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             run,
    input  logic [6:0]       opcode,
    output logic             PCWrite,
    output logic             PCIsBranch,
    output logic [1:0]       BranchType,
    output logic             IRWrite,
    output logic             IorD,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUOp,
    output logic             PCSource,
    output logic [3:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_FETCH1    = 4'd0;
    localparam logic [3:0] S_FETCH2    = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_EXEC_R    = 4'd3;
    localparam logic [3:0] S_EXEC_I    = 4'd4;
    localparam logic [3:0] S_ALU_WB    = 4'd5;
    localparam logic [3:0] S_MEM_ADDR  = 4'd6;
    localparam logic [3:0] S_MEM_READ  = 4'd7;
    localparam logic [3:0] S_MEM_WAIT  = 4'd8;
    localparam logic [3:0] S_MEM_WB    = 4'd9;
    localparam logic [3:0] S_MEM_WRITE = 4'd10;
    localparam logic [3:0] S_BRANCH    = 4'd11;
    localparam logic [3:0] S_JUMP      = 4'd12;
    localparam logic [3:0] S_HALT      = 4'd13;

    // The MEM_READ/MEM_WAIT pair is hard-wired for a single-cycle memory.
    generate
        if (MEM_LAT != 1) begin : g_bad_mem_lat
            $error("multicycle_control_unit: only MEM_LAT == 1 is supported");
        end
    endgenerate

    logic [2:0] op_class;
    logic [3:0] state_next;

    assign op_class = opcode[6:4];

    // Next-state selection; opcode is only consulted in opcode-dependent states.
    always_comb begin
        state_next = S_FETCH1;
        case (state)
            S_FETCH1:    state_next = run ? S_FETCH2 : S_FETCH1;
            S_FETCH2:    state_next = S_DECODE;
            S_DECODE: begin
                case (op_class)
                    3'b000:          state_next = S_EXEC_R;
                    3'b001:          state_next = S_EXEC_I;
                    3'b010, 3'b011:  state_next = S_MEM_ADDR;
                    3'b100:          state_next = S_BRANCH;
                    3'b101:          state_next = S_JUMP;
                    3'b111:          state_next = S_HALT;
                    default:         state_next = S_FETCH1;
                endcase
            end
            S_EXEC_R,
            S_EXEC_I:    state_next = S_ALU_WB;
            S_MEM_ADDR:  state_next = (op_class == 3'b011) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_next = S_MEM_WAIT;
            S_MEM_WAIT:  state_next = S_MEM_WB;
            S_HALT:      state_next = S_HALT;
            default:     state_next = S_FETCH1;
        endcase
    end

    // State register, fetch counter and sticky reserved-opcode flag.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_FETCH1;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (state == S_FETCH2) begin
                instr_count <= instr_count + 1'b1;
            end
            if (state == S_DECODE && op_class == 3'b110) begin
                illegal <= 1'b1;
            end
        end
    end

    // Moore output decode: everything defaults low, each state raises its own controls.
    always_comb begin
        PCWrite    = 1'b0;
        PCIsBranch = 1'b0;
        BranchType = 2'b00;
        IRWrite    = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        MemToReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 4'b0000;
        PCSource   = 1'b0;
        halted     = 1'b0;
        case (state)
            S_FETCH2: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = opcode[3:0];
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = opcode[3:0];
            end
            S_ALU_WB: RegWrite = 1'b1;
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_READ,
            S_MEM_WAIT: IorD = 1'b1;
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_MEM_WRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 4'b0001;
                PCIsBranch = 1'b1;
                BranchType = opcode[1:0];
                PCSource   = 1'b1;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore FSM that sequences the multi-cycle datapath.
- Consumes the 7-bit opcode latched in the instruction register.
- Drives the fetch/memory stage controls (PC write/branch, IR write, address select, memory write) and the register-file/ALU controls for each instruction class.
- Also provides run/halt gating, an executed-instruction counter and a sticky illegal-opcode flag.

Parameters:
- MEM_LAT, 1, memory read latency in cycles (q valid MEM_LAT cycles after address). Only 1 is supported; any other value is an elaboration error.
- CNT_W, 16, width of the instruction counter.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- run  in  1  when 0, FSM holds in FETCH1 (no new fetch)
- opcode  in  7  IR control field; [6:4] = class, [3:0] = ALU op / branch type
- PCWrite  out  1  unconditional PC update
- PCIsBranch  out  1  conditional PC update (PC applies zero/negative per BranchType)
- BranchType  out  2  opcode[1:0] during BRANCH, else 0
- IRWrite  out  1  IR capture enable
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write enable
- RegWrite  out  1  register-file write enable
- MemToReg  out  1  write-back source: 0 = ALUOut, 1 = MDR
- ALUSrcA  out  1  0 = PC, 1 = RegA
- ALUSrcB  out  2  00 = RegB, 01 = constant 1, 10 = Imm
- ALUOp  out  4  ALU function
- PCSource  out  1  0 = ALU result, 1 = ALUOut
- state  out  4  current state encoding, for debug
- halted  out  1  high in HALT
- illegal  out  1  sticky: reserved opcode seen
- instr_count  out  CNT_W  number of completed fetches

Behaviour:
- Outputs decode combinationally from `state` only. Every output not listed for a state is 0.
- Reset (RST_N low) asynchronously forces:
  - state = FETCH1 (0)
  - illegal = 0, instr_count = 0
  - all control outputs = 0; MemWrite drops immediately, including mid-store.
- State encodings: FETCH1=0, FETCH2=1, DECODE=2, EXEC_R=3, EXEC_I=4, ALU_WB=5, MEM_ADDR=6, MEM_READ=7, MEM_WAIT=8, MEM_WB=9, MEM_WRITE=10, BRANCH=11, JUMP=12, HALT=13.
- FETCH1: IorD=0, presents PC to memory.
  - run=1 → FETCH2; run=0 → stay in FETCH1.
- FETCH2: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=0000 (PC+1), PCSource=0. instr_count increments (wraps at 2^CNT_W). → DECODE.
- DECODE branches on opcode[6:4]:
  - 000 → EXEC_R
  - 001 → EXEC_I
  - 010, 011 → MEM_ADDR
  - 100 → BRANCH
  - 101 → JUMP
  - 110 → set illegal, → FETCH1
  - 111 → HALT
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=opcode[3:0]. → ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=opcode[3:0]. → ALU_WB.
- ALU_WB: RegWrite=1, MemToReg=0. → FETCH1.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=0000.
  - class 010 (load) → MEM_READ
  - class 011 (store) → MEM_WRITE
- MEM_READ: IorD=1. → MEM_WAIT.
- MEM_WAIT: IorD=1; MDR captures q at the end of this cycle. → MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1. → FETCH1.
- MEM_WRITE: IorD=1, MemWrite=1 for exactly one cycle. → FETCH1.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=0001 (subtract), PCIsBranch=1, BranchType=opcode[1:0], PCSource=1. → FETCH1.
- JUMP: PCWrite=1, PCSource=1. → FETCH1.
- HALT: halted=1, all other controls 0. Stays until reset; run is ignored.
- Opcode is sampled only in DECODE, MEM_ADDR and the opcode-dependent states. IR is stable because IRWrite is asserted only in FETCH2.
- Cycles per instruction (run held high):
  - R/I-type 5
  - load 7
  - store 5
  - branch 4
  - jump 4
  - reserved 3
- run deasserted in any state other than FETCH1 has no effect until the FSM returns to FETCH1.
- illegal is cleared only by reset.

Test Plan:
- Reset, then release with run=0 for 5 cycles → state=0, all controls 0, instr_count=0. Then raise run → FETCH2 on the next edge with IRWrite=PCWrite=1.
- opcode=7'b000_0010 (R-type) → state sequence 0,1,2,3,5,0; ALUOp=0010 in EXEC_R; RegWrite=1 only in ALU_WB; instr_count=1.
- opcode=7'b010_0000 (load) → sequence 0,1,2,6,7,8,9,0; IorD=1 in states 7 and 8; MemToReg=RegWrite=1 in state 9.
- opcode=7'b011_0000 (store) with RST_N pulsed low during MEM_WRITE → MemWrite falls asynchronously; state=0 and instr_count=0 immediately.
- opcode=7'b100_0010 (branch) → BRANCH asserts PCIsBranch=1, BranchType=10, PCSource=1 for one cycle. Then opcode=7'b110_0000 → illegal=1 stays set through later instructions.
- opcode=7'b111_0000 → halted=1, state=13 held for 20 cycles with run toggling; instr_count frozen; reset returns state to 0.
